block_transfer_sequencer: RTL and testbench
===========================================

// Module: block_transfer_sequencer
// PURPOSE
//  Sequences LDM/STM block transfers between the 16-entry register file and memory.
//  Walks a 16-bit register list lowest-index first, one word per handshake.
//  STM: drives read_rn and forwards rn_out to memory. LDM: drives rd_we/write_rd/rd_in from memory data.
//  Optionally writes the updated base back through the same rd port. Sits between decode/control and register_file.
// PARAMETERS
//  WORD_SIZE   32  datapath / address width
//  NUM_REGS    16  register count; also reg_list width
//  ADDR_WIDTH  4   register index width
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-low reset
//  start      in   1   launch a transfer; sampled only in IDLE
//  is_load    in   1   1 = LDM, 0 = STM
//  up         in   1   1 = increment, 0 = decrement
//  pre        in   1   1 = before, 0 = after (IB/DB vs IA/DA)
//  wback      in   1   write final address back to base_reg
//  base_reg   in   4   base register index
//  base_addr  in   32  base register value at start
//  reg_list   in   16  bit i set = transfer Ri
//  rn_out     in   32  register file read data for read_rn
//  mem_rdata  in   32  load data, valid with mem_ack
//  mem_ack    in   1   memory accepts/completes the current request
//  read_rn    out  4   register index presented to register file
//  rd_we      out  1   register file write enable
//  write_rd   out  4   register file write index
//  rd_in      out  32  register file write data
//  mem_req    out  1   memory request; held until mem_ack
//  mem_we     out  1   1 = store
//  mem_addr   out  32  word address of current transfer
//  mem_wdata  out  32  store data (= rn_out)
//  busy       out  1   high from cycle after start until done
//  done       out  1   one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, any state): state IDLE; all outputs 0; latched list/address cleared; in-flight transfer abandoned.
//  States: IDLE -> XFER -> (WB) -> DONE -> IDLE.
//  IDLE: start=1 latches all inputs at edge N; n = popcount(reg_list).
//    n=0 -> DONE at N+1; no mem traffic, no writeback.
//    n>0 -> XFER at N+1.
//  Start address: IA base; IB base+4; DA base-4n+4; DB base-4n.
//    Final address: up ? base+4n : base-4n. Arithmetic is mod 2^32.
//  Ascending register index always maps to ascending addresses.
//  XFER: mem_req=1; mem_addr = current address; mem_we = ~is_load; cur = lowest set bit of remaining mask.
//    STM: read_rn = cur; mem_wdata = rn_out (combinational).
//    LDM: on the mem_ack cycle rd_we=1, write_rd=cur, rd_in=mem_rdata (combinational).
//    mem_ack=0: all request outputs held stable.
//    mem_ack=1: clear cur from the mask; address += 4.
//      Mask non-empty -> next request presented the following cycle, mem_req stays high.
//      Mask empty -> WB if wback and not (is_load and reg_list[base_reg]); else DONE.
//  WB: one cycle; rd_we=1, write_rd=base_reg, rd_in=final address; mem_req=0.
//  DONE: done=1, busy=0 for one cycle; then IDLE. start ignored in every non-IDLE state.
//  LDM including base with wback: loaded value wins; writeback suppressed.
//  R15 in the list is an ordinary index; no PC/CPSR side effects.
//  rd_we is 0 in every state and cycle other than those listed above.
// STRUCTURE
//  Shared package armcpu_pkg: WORD_SIZE, NUM_REGS, ADDR_WIDTH, state encoding (IDLE/XFER/WB/DONE).
//  Sub-module reg_list_scanner: combinational lowest-set-bit index, plus popcount of a 16-bit mask.
//  Top level: FSM, address/mask registers, output muxing.
// TESTING
//  STM IA, base 0x100, list 0x000B, ack tied 1:
//    mem_addr 0x100/0x104/0x108 with read_rn 0/1/3 on consecutive cycles; done 4 cycles after start edge.
//  LDM DB wback, base_reg 13, base 0x200, list 0x8003, mem_rdata = addr:
//    writes R0=0x1F4, R1=0x1F8, R15=0x1FC; then WB R13=0x1F4; done.
//  LDM IB, ack delayed 3 cycles per beat:
//    mem_req/mem_addr stable while ack=0; exactly one rd_we pulse per ack.
//  list 0x0000 -> done pulse 1 cycle after start; mem_req never rises; rd_we never rises.
//  LDM IA wback, base_reg 2, list 0x0004 -> R2 gets load data; no WB cycle.
//  reset low mid-XFER -> all outputs 0 immediately; start after release runs a clean new transfer.
//  start re-asserted while busy -> ignored; transfer sequence unchanged.

Source files
------------

// File: rtl/armcpu_pkg.sv
// Shared widths and FSM encoding for the
// block transfer sequencer slice.
package armcpu_pkg;
  localparam int WORD_SIZE  = 32;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_t;
endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Word memory request/ack port used by the
// block transfer sequencer.
interface block_transfer_sequencer_if;
  import armcpu_pkg::*;

  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ack;

  modport master (
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/reg_list_scanner.sv
// Lowest-set-bit index and popcount of a
// register list mask.
module reg_list_scanner
  import armcpu_pkg::*;
(
  input  logic [NUM_REGS-1:0]   mask,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    idx   = '0;
    count = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) idx = ADDR_WIDTH'(i);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      count = count + CNT_WIDTH'(mask[i]);
    end
  end

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks a register list
// one word per memory handshake.
module block_transfer_sequencer
  import armcpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  up,
  input  logic                  pre,
  input  logic                  wback,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_addr,
  input  logic [NUM_REGS-1:0]   reg_list,
  input  logic [WORD_SIZE-1:0]  rn_out,
  block_transfer_sequencer_if.master mem,
  output logic [ADDR_WIDTH-1:0] read_rn,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [NUM_REGS-1:0]   mask_q;
  logic [WORD_SIZE-1:0]  addr_q;
  logic [WORD_SIZE-1:0]  final_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  load_q;
  logic                  wb_q;
  logic                  req_q;

  logic [NUM_REGS-1:0]   scan_in;
  logic [NUM_REGS-1:0]   mask_nxt;
  logic [ADDR_WIDTH-1:0] cur;
  logic [CNT_WIDTH-1:0]  count;
  logic [WORD_SIZE-1:0]  four_n;
  logic [WORD_SIZE-1:0]  low_addr;
  logic [WORD_SIZE-1:0]  start_addr;
  logic [WORD_SIZE-1:0]  final_addr;
  logic                  xfer;
  logic                  st_beat;
  logic                  ld_beat;
  logic                  wb_cyc;

  // IDLE scans the incoming list for popcount;
  // XFER scans the remaining mask for cur.
  assign scan_in = (state == IDLE) ? reg_list : mask_q;

  reg_list_scanner u_scan (
    .mask  (scan_in),
    .idx   (cur),
    .count (count)
  );

  assign mask_nxt = mask_q & (mask_q - 1'b1);
  assign four_n   = WORD_SIZE'(count) << 2;
  assign low_addr = base_addr - four_n;

  assign start_addr =
    up ? (pre ? base_addr + 32'd4 : base_addr)
       : (pre ? low_addr : low_addr + 32'd4);
  assign final_addr =
    up ? base_addr + four_n : low_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      final_q <= '0;
      base_q  <= '0;
      load_q  <= 1'b0;
      wb_q    <= 1'b0;
      req_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mask_q  <= reg_list;
            addr_q  <= start_addr;
            final_q <= final_addr;
            base_q  <= base_reg;
            load_q  <= is_load;
            // A loaded base value beats the writeback.
            wb_q    <= wback &&
                       !(is_load && reg_list[base_reg]);
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= XFER;
              req_q <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        XFER: begin
          if (mem.mem_ack) begin
            mask_q <= mask_nxt;
            addr_q <= addr_q + 32'd4;
            if (mask_nxt == '0) begin
              req_q <= 1'b0;
              if (wb_q) begin
                state <= WB;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        WB: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign xfer    = (state == XFER);
  assign st_beat = xfer & ~load_q;
  assign ld_beat = xfer & load_q & mem.mem_ack;
  assign wb_cyc  = (state == WB);

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = st_beat;
  assign mem.mem_addr  = xfer ? addr_q : '0;
  assign mem.mem_wdata = st_beat ? rn_out : '0;

  assign read_rn  = st_beat ? cur : '0;
  assign rd_we    = ld_beat | wb_cyc;
  assign write_rd = ld_beat ? cur :
                    wb_cyc  ? base_q : '0;
  assign rd_in    = ld_beat ? mem.mem_rdata :
                    wb_cyc  ? final_q : '0;

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed vector bench for the block
// transfer sequencer.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [15:0] reg_list = '0;
  logic [31:0] rn_out;
  logic [3:0]  read_rn;
  logic        rd_we;
  logic [3:0]  write_rd;
  logic [31:0] rd_in;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  block_transfer_sequencer_if bus ();

  block_transfer_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_load   (is_load),
    .up        (up),
    .pre       (pre),
    .wback     (wback),
    .base_reg  (base_reg),
    .base_addr (base_addr),
    .reg_list  (reg_list),
    .rn_out    (rn_out),
    .mem       (bus),
    .read_rn   (read_rn),
    .rd_we     (rd_we),
    .write_rd  (write_rd),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Memory returns its address as load data;
  // the register file returns a tagged index.
  assign bus.mem_rdata = bus.mem_addr;
  assign rn_out = 32'hA000_0000 | {28'd0, read_rn};

  typedef struct {
    logic        ld, up, pre, wb;
    logic [3:0]  br;
    logic [31:0] base;
    logic [15:0] list;
    logic [31:0] sa, fa;
    int          n;
    bit          exp_wb;
    int          dly;
    bit          restart;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"}, 32'(bus.mem_req), 0);
    chk({tag, "_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rn"}, 32'(read_rn), 0);
    chk({tag, "_rdwe"}, 32'(rd_we), 0);
    chk({tag, "_wrd"}, 32'(write_rd), 0);
    chk({tag, "_rdin"}, rd_in, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic run(input vec_t v);
    int idx[16];
    int k, cyc, beat, wbs, rdw, wcnt;
    bit fin, prev_req, prev_ack;
    logic [31:0] prev_addr, ea;
    k = 0;
    for (int i = 0; i < 16; i++)
      if (v.list[i]) begin
        idx[k] = i;
        k++;
      end
    @(negedge clk);
    is_load = v.ld; up = v.up; pre = v.pre;
    wback = v.wb; base_reg = v.br;
    base_addr = v.base; reg_list = v.list;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = v.restart;
    if (v.restart) begin
      reg_list = 16'hFFFF;
      is_load = ~v.ld;
      base_addr = 32'h0;
    end
    cyc = 1; beat = 0; wbs = 0; rdw = 0;
    wcnt = 0; fin = 0;
    prev_req = 0; prev_ack = 0; prev_addr = 0;
    while (!fin && cyc < 200) begin
      bus.mem_ack = bus.mem_req && (wcnt == v.dly);
      #1;
      if (bus.mem_req && prev_req && !prev_ack)
        chk("hold_addr", bus.mem_addr, prev_addr);
      if (bus.mem_req) begin
        if (bus.mem_ack) begin
          if (beat < v.n) begin
            ea = v.sa + 32'(4 * beat);
            chk("addr", bus.mem_addr, ea);
            chk("mem_we", 32'(bus.mem_we), 32'(!v.ld));
            if (v.ld) begin
              chk("ld_we", 32'(rd_we), 1);
              chk("ld_rd", 32'(write_rd), idx[beat]);
              chk("ld_data", rd_in, ea);
            end else begin
              chk("st_we", 32'(rd_we), 0);
              chk("st_rn", 32'(read_rn), idx[beat]);
              chk("st_data", bus.mem_wdata,
                  32'hA000_0000 | 32'(idx[beat]));
            end
          end else begin
            chk("extra_beat", beat, v.n);
          end
          beat++;
          wcnt = 0;
        end else begin
          chk("wait_we", 32'(rd_we), 0);
          wcnt++;
        end
      end else if (rd_we) begin
        chk("wb_rd", 32'(write_rd), 32'(v.br));
        chk("wb_data", rd_in, v.fa);
        wbs++;
      end
      if (rd_we) rdw++;
      if (done) begin
        chk("done_cyc", cyc,
            v.n * (v.dly + 1) + int'(v.exp_wb) + 1);
        chk("beats", beat, v.n);
        chk("wb_cnt", wbs, int'(v.exp_wb));
        chk("rdwe_cnt", rdw,
            (v.ld ? v.n : 0) + int'(v.exp_wb));
        chk("done_busy", 32'(busy), 0);
        chk("done_req", 32'(bus.mem_req), 0);
        fin = 1;
        start = 1'b0;
      end else begin
        chk("busy", 32'(busy), 1);
      end
      prev_req = bus.mem_req;
      prev_ack = bus.mem_ack;
      prev_addr = bus.mem_addr;
      @(negedge clk);
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    bus.mem_ack = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    //       ld up pre wb br base list sa fa n wb dly rs
    tv[0] = '{0, 1, 0, 0, 4'd0, 32'h100, 16'h000B,
              32'h100, 32'h10C, 3, 0, 0, 0};
    tv[1] = '{1, 0, 1, 1, 4'd13, 32'h200, 16'h8003,
              32'h1F4, 32'h1F4, 3, 1, 1, 0};
    tv[2] = '{1, 1, 1, 1, 4'd3, 32'h1000, 16'h0030,
              32'h1004, 32'h1008, 2, 1, 3, 0};
    tv[3] = '{0, 1, 0, 1, 4'd5, 32'h300, 16'h0000,
              32'h300, 32'h300, 0, 0, 0, 0};
    tv[4] = '{1, 1, 0, 1, 4'd2, 32'h40, 16'h0004,
              32'h40, 32'h44, 1, 0, 0, 0};
    tv[5] = '{0, 0, 0, 1, 4'd1, 32'h8, 16'h00F0,
              32'hFFFF_FFFC, 32'hFFFF_FFF8, 4, 1, 0, 0};
    tv[6] = '{0, 1, 1, 1, 4'd0, 32'hFFFF_FFF8, 16'h8001,
              32'hFFFF_FFFC, 32'h0, 2, 1, 0, 1};

    #3;
    chk_quiet("rst");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run(tv[i]);

    // Abandon a stalled transfer with reset.
    @(negedge clk);
    is_load = 1'b0; up = 1'b1; pre = 1'b0;
    wback = 1'b1; base_reg = 4'd1;
    base_addr = 32'h500; reg_list = 16'h00FF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus.mem_req), 1);
    chk("pre_rst_addr", bus.mem_addr, 32'h500);
    reset = 1'b0;
    #1;
    chk_quiet("midrst");
    @(negedge clk);
    chk_quiet("midrst_hold");
    reset = 1'b1;
    run(tv[0]);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
